comp_fir_mc: RTL and testbench

Multi-channel, runtime-programmable compensation FIR for the DFE decimation chain, placed directly after the CIC decimator at CIC output rate. One time-shared multiply-accumulate serves NCH interleaved channels, for example I/Q. Coefficients live in NBANK writable banks, each with its own tap length, so any decimation ratio can be compensated without re-synthesis. Valid/ready handshakes on input and output let the block stall upstream while a sample is being computed.

---
 rtl/comp_fir_pkg.sv | 65 ++++++
 rtl/comp_fir_coef_bank.sv | 50 +++++
 rtl/comp_fir_mc.sv | 164 ++++++++++++++++
 tb/tb_comp_fir_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_fir_pkg.sv
// Shared types, constants and the round/saturate helper for the
// multi-channel compensation FIR.
package comp_fir_pkg;

  localparam int W         = 28;  // sample width
  localparam int FRAC      = 15;  // sample fractional bits (format carried through unchanged)
  localparam int CW        = 28;  // coefficient width, Q1.(CW-1)
  localparam int NTAPS_MAX = 22;  // maximum taps per bank
  localparam int NCH       = 2;   // interleaved channels
  localparam int NBANK     = 5;   // coefficient banks
  localparam int ACCW      = W + CW + $clog2(NTAPS_MAX);

  localparam int CHW   = $clog2(NCH);
  localparam int BANKW = $clog2(NBANK);
  localparam int ADDRW = $clog2(NTAPS_MAX + 1);
  localparam int TAPW  = $clog2(NTAPS_MAX);
  localparam int LENW  = ADDRW;

  typedef logic signed [W-1:0]    sample_t;
  typedef logic signed [CW-1:0]   coeff_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic [CHW-1:0]         ch_t;
  typedef logic [BANKW-1:0]       bank_t;
  typedef logic [ADDRW-1:0]       addr_t;
  typedef logic [TAPW-1:0]        tap_t;
  typedef logic [LENW-1:0]        len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2
  } state_e;

  typedef struct packed {
    sample_t sample;
    logic    sat;
  } rs_t;

  localparam tap_t  TAP_LAST  = tap_t'(NTAPS_MAX - 1);
  localparam len_t  LEN_MAX   = len_t'(NTAPS_MAX);
  localparam bank_t BANK_LAST = bank_t'(NBANK - 1);
  localparam addr_t ADDR_LEN  = addr_t'(NTAPS_MAX);

  localparam acc_t RND_BIAS = acc_t'(1) <<< (CW - 2);
  localparam acc_t SAT_MAX  = acc_t'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam acc_t SAT_MIN  = acc_t'(-(64'sd1 <<< (W - 1)));

  // Round half-up back to sample scale, then clamp to the sample range.
  function automatic rs_t round_sat(input acc_t acc);
    acc_t r;
    rs_t  res;
    r          = (acc + RND_BIAS) >>> (CW - 1);
    res.sat    = 1'b0;
    res.sample = r[W-1:0];
    if (r > SAT_MAX) begin
      res.sample = sample_t'(SAT_MAX);
      res.sat    = 1'b1;
    end else if (r < SAT_MIN) begin
      res.sample = sample_t'(SAT_MIN);
      res.sat    = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/comp_fir_coef_bank.sv
// Coefficient and tap-length storage: NBANK banks of NTAPS_MAX
// coefficients plus one length register per bank. One write port,
// one combinational read port.
module comp_fir_coef_bank
  import comp_fir_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   cfg_we,
  input  bank_t  cfg_bank,
  input  addr_t  cfg_addr,
  input  coeff_t cfg_data,
  input  bank_t  rd_bank,
  input  tap_t   rd_tap,
  output coeff_t rd_coef,
  output len_t   rd_len
);

  coeff_t r_coef [NBANK][NTAPS_MAX];
  len_t   r_len  [NBANK];

  // Configuration writes; address NTAPS_MAX targets the bank length.
  // NOTE: these registers are reset on purpose: a zero length is what puts
  // every bank in bypass after reset, so this storage cannot be left as RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++) begin
        r_len[b] <= '0;
        for (int t = 0; t < NTAPS_MAX; t++) r_coef[b][t] <= '0;
      end
    end else if (cfg_we && (cfg_bank <= BANK_LAST)) begin
      if (cfg_addr == ADDR_LEN)
        r_len[cfg_bank] <= cfg_data[LENW-1:0];
      else if (cfg_addr < ADDR_LEN)
        r_coef[cfg_bank][cfg_addr] <= cfg_data;
    end
  end

  // Combinational read; out-of-range selects read as zero.
  // NOTE: every output gets a default first so no latch can be inferred.
  always_comb begin
    rd_coef = '0;
    rd_len  = '0;
    if (rd_bank <= BANK_LAST) begin
      rd_len = r_len[rd_bank];
      if (rd_tap <= TAP_LAST) rd_coef = r_coef[rd_bank][rd_tap];
    end
  end

endmodule

// File: rtl/comp_fir_mc.sv
// Multi-channel runtime-programmable compensation FIR. One shared
// multiply-accumulate walks the taps of the selected bank for each
// accepted sample; zero or oversize lengths, or comp_enable=0, bypass.
module comp_fir_mc
  import comp_fir_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  ch_t            in_ch,
  input  sample_t        in_sample,
  input  bank_t          bank_sel,
  input  logic           comp_enable,
  output logic           out_valid,
  input  logic           out_ready,
  output ch_t            out_ch,
  output sample_t        out_sample,
  input  logic           cfg_we,
  input  bank_t          cfg_bank,
  input  addr_t          cfg_addr,
  input  coeff_t         cfg_data,
  input  logic           ovf_clr,
  output logic [NCH-1:0] ovf_flag
);

  state_e          r_state;
  sample_t         r_x [NCH][NTAPS_MAX];
  tap_t            r_wp [NCH];
  ch_t             r_ch;
  bank_t           r_bank;
  sample_t         r_sample;
  len_t            r_len;
  logic            r_byp;
  tap_t            r_tap;
  tap_t            r_rd_ptr;
  acc_t            r_acc;
  logic            r_out_valid;
  ch_t             r_out_ch;
  sample_t         r_out_sample;
  logic [NCH-1:0]  r_ovf;

  logic                   w_accept;
  bank_t                  w_rd_bank;
  tap_t                   w_rd_tap;
  coeff_t                 w_coef;
  len_t                   w_len;
  logic                   w_len_ok;
  sample_t                w_x;
  logic signed [W+CW-1:0] w_prod;
  rs_t                    w_rs;
  logic [NCH-1:0]         w_ovf_set;

  assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign out_sample = r_out_sample;
  assign ovf_flag   = r_ovf;

  // While idle the read port looks up the length for the incoming sample;
  // during MAC it serves the latched bank at the current tap.
  assign w_rd_bank = (r_state == IDLE) ? bank_sel : r_bank;
  assign w_rd_tap  = (r_state == IDLE) ? '0 : r_tap;
  assign w_len_ok  = (w_len != '0) && (w_len <= LEN_MAX);

  comp_fir_coef_bank u_coef_bank (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_bank (cfg_bank),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_bank  (w_rd_bank),
    .rd_tap   (w_rd_tap),
    .rd_coef  (w_coef),
    .rd_len   (w_len)
  );

  assign w_x    = r_x[r_ch][r_rd_ptr];
  assign w_prod = (W+CW)'(w_x) * (W+CW)'(w_coef);
  assign w_rs   = round_sat(r_acc);

  // Per-channel circular delay lines and write pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_wp[c] <= '0;
        for (int t = 0; t < NTAPS_MAX; t++) r_x[c][t] <= '0;
      end
    end else if (w_accept) begin
      r_x[in_ch][r_wp[in_ch]] <= in_sample;
      r_wp[in_ch] <= (r_wp[in_ch] == TAP_LAST) ? '0 : r_wp[in_ch] + tap_t'(1);
    end
  end

  // Sequencer: latch the sample context on accept, walk the taps newest
  // first while accumulating, then hand over to the rounding cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_bank   <= '0;
      r_sample <= '0;
      r_len    <= '0;
      r_byp    <= 1'b1;
      r_tap    <= '0;
      r_rd_ptr <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ch     <= in_ch;
          r_bank   <= bank_sel;
          r_sample <= in_sample;
          r_len    <= w_len;
          r_tap    <= '0;
          r_rd_ptr <= r_wp[in_ch];
          r_acc    <= '0;
          r_byp    <= !(comp_enable && w_len_ok);
          r_state  <= (comp_enable && w_len_ok) ? MAC : RND;
        end
        MAC: begin
          r_acc    <= r_acc + acc_t'(w_prod);
          r_tap    <= r_tap + tap_t'(1);
          r_rd_ptr <= (r_rd_ptr == '0) ? TAP_LAST : r_rd_ptr - tap_t'(1);
          if (r_tap == tap_t'(r_len - len_t'(1))) r_state <= RND;
        end
        RND:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: loaded by RND, released by a downstream handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_sample <= '0;
    end else if (r_state == RND) begin
      r_out_valid  <= 1'b1;
      r_out_ch     <= r_ch;
      r_out_sample <= r_byp ? r_sample : w_rs.sample;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturation events from filtered samples only.
  always_comb begin
    w_ovf_set = '0;
    if ((r_state == RND) && !r_byp && w_rs.sat) w_ovf_set[r_ch] = 1'b1;
  end

  // Sticky flags; a new saturation wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) r_ovf <= '0;
    else       r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
  end

endmodule

// File: tb/tb_comp_fir_mc.sv
// Scoreboard bench for comp_fir_mc: a reference model computes each
// expected output at accept time; a monitor pops and compares on handshake.
module tb_comp_fir_mc;
  import comp_fir_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  ch_t            in_ch;
  sample_t        in_sample;
  bank_t          bank_sel;
  logic           comp_enable;
  logic           out_valid;
  logic           out_ready;
  ch_t            out_ch;
  sample_t        out_sample;
  logic           cfg_we;
  bank_t          cfg_bank;
  addr_t          cfg_addr;
  coeff_t         cfg_data;
  logic           ovf_clr;
  logic [NCH-1:0] ovf_flag;

  comp_fir_mc dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_sample   (in_sample),
    .bank_sel    (bank_sel),
    .comp_enable (comp_enable),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sample  (out_sample),
    .cfg_we      (cfg_we),
    .cfg_bank    (cfg_bank),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ovf_clr     (ovf_clr),
    .ovf_flag    (ovf_flag)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int     ch;
    longint val;
    longint acyc;
    int     lat;
    bit     chk_lat;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint mx[NCH][NTAPS_MAX];
  int     mwp[NCH];
  longint mcoef[NBANK][NTAPS_MAX];
  int     mlen[NBANK];
  bit     movf[NCH];
  bit     lat_en;

  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      mwp[c]  = 0;
      movf[c] = 1'b0;
      for (int t = 0; t < NTAPS_MAX; t++) mx[c][t] = 0;
    end
    for (int b = 0; b < NBANK; b++) begin
      mlen[b] = 0;
      for (int t = 0; t < NTAPS_MAX; t++) mcoef[b][t] = 0;
    end
    sb.delete();
  endtask

  task automatic model_accept(input int ch, input longint s, input int bank,
                              input bit en, input longint acyc);
    exp_t   e;
    longint acc;
    longint r;
    int     l;
    int     idx;
    mx[ch][mwp[ch]] = s;
    mwp[ch] = (mwp[ch] + 1) % NTAPS_MAX;
    l = mlen[bank];
    if (en && l >= 1 && l <= NTAPS_MAX) begin
      acc = 0;
      for (int i = 0; i < l; i++) begin
        idx = (mwp[ch] - 1 - i + 2 * NTAPS_MAX) % NTAPS_MAX;
        acc += mx[ch][idx] * mcoef[bank][i];
      end
      r = (acc + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
      if (r > SMAX) begin r = SMAX; movf[ch] = 1'b1; end
      if (r < SMIN) begin r = SMIN; movf[ch] = 1'b1; end
      e.lat = l + 2;
    end else begin
      r = s;
      e.lat = 2;
    end
    e.ch = ch;
    e.val = r;
    e.acyc = acyc;
    e.chk_lat = lat_en;
    sb.push_back(e);
  endtask

  task automatic cfg(input int bank, input int addr, input longint v);
    @(posedge clk); #2;
    cfg_we   = 1'b1;
    cfg_bank = bank_t'(bank);
    cfg_addr = addr_t'(addr);
    cfg_data = v[CW-1:0];
    @(posedge clk); #2;
    cfg_we = 1'b0;
    if (addr == NTAPS_MAX) mlen[bank] = int'(v & ((64'sd1 <<< LENW) - 1));
    else                   mcoef[bank][addr] = v;
  endtask

  task automatic send(input int ch, input longint s, input int bank, input bit en);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #2;
    in_valid    = 1'b1;
    in_ch       = ch_t'(ch);
    in_sample   = s[W-1:0];
    bank_sel    = bank_t'(bank);
    comp_enable = en;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(ch, s, bank, en, cyc);
        @(posedge clk);
        acc = 1'b1;
        break;
      end
    end
    #2 in_valid = 1'b0;
    if (!acc) check("accept_timeout", longint'(acc), 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain", sb.size(), 0);
  endtask

  // Output monitor: compare every handshaken output against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("out_ch", longint'(out_ch), mon_e.ch);
        check("out_sample", longint'(out_sample), mon_e.val);
        if (mon_e.chk_lat) check("latency", cyc - mon_e.acyc, mon_e.lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t held;
    bit      seen;
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_sample = '0; bank_sel = '0;
    comp_enable = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_bank = '0;
    cfg_addr = '0; cfg_data = '0; ovf_clr = 1'b0; lat_en = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sample", longint'(out_sample), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    check("rst_ovf", longint'(ovf_flag), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // Bypass after reset (all lengths 0)
    send(0, 100, 0, 1'b1);
    send(0, -5, 0, 1'b1);
    wait_drain();
    check("bypass_ovf", longint'(ovf_flag), 0);

    // Impulse through bank 1, ch0 history flushed with bypassed zeros
    cfg(1, 0, 64'sd1 <<< 26);
    cfg(1, 1, 64'sd1 <<< 25);
    cfg(1, 2, -(64'sd1 <<< 25));
    cfg(1, NTAPS_MAX, 3);
    for (int i = 0; i < 3; i++) send(0, 0, 1, 1'b0);
    send(0, 1000, 1, 1'b1);
    for (int i = 0; i < 3; i++) send(0, 0, 1, 1'b1);
    wait_drain();

    // Channel isolation: interleave ch0 impulse with ch1 zeros
    for (int i = 0; i < 3; i++) send(0, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 1000 : 0, 1, 1'b1);
      send(1, 0, 1, 1'b1);
    end
    wait_drain();

    // Positive saturation, sticky flag, clear
    cfg(2, 0, SMAX);
    cfg(2, 1, SMAX);
    cfg(2, NTAPS_MAX, 2);
    send(0, SMAX, 2, 1'b1);
    send(0, SMAX, 2, 1'b1);
    wait_drain();
    check("sat_ovf0", longint'(ovf_flag[0]), longint'(movf[0]));
    check("sat_ovf1", longint'(ovf_flag[1]), longint'(movf[1]));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_ovf0_sticky", longint'(ovf_flag[0]), 1);
    @(posedge clk); #2 ovf_clr = 1'b1;
    @(posedge clk); #2 ovf_clr = 1'b0;
    movf[0] = 1'b0;
    @(negedge clk);
    check("ovf_cleared", longint'(ovf_flag), 0);

    // Negative saturation on ch0
    send(0, SMIN, 2, 1'b1);
    send(0, SMIN, 2, 1'b1);
    wait_drain();
    check("negsat_ovf0", longint'(ovf_flag[0]), longint'(movf[0]));

    // Oversize length is bypass
    cfg(4, NTAPS_MAX, 25);
    send(1, 12345, 4, 1'b1);
    wait_drain();
    check("oversize_ovf1", longint'(ovf_flag[1]), 0);

    // Backpressure: hold the first output, second sample must wait
    lat_en = 1'b0;
    @(posedge clk); #2 out_ready = 1'b0;
    send(0, 1000, 1, 1'b1);
    fork
      send(1, 777, 0, 1'b1);
    join_none
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid", longint'(seen), 1);
    held = out_sample;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_hold", longint'(out_sample), longint'(held));
    end
    @(posedge clk); #2 out_ready = 1'b1;
    wait fork;
    wait_drain();
    lat_en = 1'b1;

    // Reset in cycle 2 of a 22-tap computation
    for (int t = 0; t < NTAPS_MAX; t++) cfg(3, t, 64'sd1 <<< 20);
    cfg(3, NTAPS_MAX, 22);
    send(0, 500, 3, 1'b1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check("rstmac_out_valid", longint'(out_valid), 0);
    check("rstmac_in_ready", longint'(in_ready), 1);
    @(posedge clk); #2 reset = 1'b0;
    send(0, 321, 3, 1'b1);
    wait_drain();
    check("rstmac_ovf", longint'(ovf_flag), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
